shift_add_mult_seq: RTL

- Sequential unsigned multiplier controller for the MultiplicationUnit.
- Time-shares a single 4-bit adder slice (A+B+CI -> {CO,Sum}) across all nibbles of a WIDTH x WIDTH shift-add multiply.
- Sequences nibble-serial partial-product accumulation and the right shifts, and presents a start/busy/done handshake to the surrounding logic.

---
 rtl/shift_add_mult_seq_if.sv | 22 ++
 rtl/shift_add_mult_seq.sv | 108 ++++++++++
 2 files changed

// File: rtl/shift_add_mult_seq_if.sv
// Handshake and operand/result bundle for the sequential shift-add multiplier.
// master drives the request side, slave (the multiplier) drives status and result.
interface shift_add_mult_seq_if #(
  parameter int WIDTH = 8
);
  logic                 Start;
  logic [WIDTH-1:0]     Multiplicand;
  logic [WIDTH-1:0]     Multiplier;
  logic                 Busy;
  logic                 Done;
  logic [2*WIDTH-1:0]   Product;

  modport master (
    output Start, Multiplicand, Multiplier,
    input  Busy, Done, Product
  );

  modport slave (
    input  Start, Multiplicand, Multiplier,
    output Busy, Done, Product
  );
endinterface

// File: rtl/shift_add_mult_seq.sv
// Sequential unsigned WIDTH x WIDTH multiplier. One 4-bit adder slice is
// time-shared across the nibbles of the running sum: every multiplier one-bit
// costs NIB add passes plus a shift, every zero-bit costs a single shift.
module shift_add_mult_seq #(
  parameter int WIDTH = 8
) (
  input  logic              Clock,
  input  logic              Reset_n,
  shift_add_mult_seq_if.slave bus
);

  localparam int NIB = WIDTH / 4;
  localparam int NW  = (NIB > 1) ? $clog2(NIB) : 1;
  localparam int BW  = $clog2(WIDTH);

  localparam logic [NW-1:0] NIB_LAST = NW'(NIB - 1);
  localparam logic [BW-1:0] BIT_LAST = BW'(WIDTH - 1);

  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] ADD   = 2'd1;
  localparam logic [1:0] SHIFT = 2'd2;
  localparam logic [1:0] DONE  = 2'd3;

  logic [1:0]         state;
  logic [2*WIDTH-1:0] p;        // upper half: running sum, lower half: unconsumed multiplier bits
  logic [WIDTH-1:0]   m;        // latched multiplicand
  logic [NW-1:0]      nib;      // nibble currently fed to the adder slice
  logic [BW-1:0]      bitcnt;   // multiplier bit being retired
  logic               c;        // carry between nibble passes, shifted in as the new MSB
  logic [2*WIDTH-1:0] product;

  logic [3:0]         add_a;
  logic [3:0]         add_b;
  logic [3:0]         add_sum;
  logic               add_co;
  logic [2*WIDTH-1:0] shifted;

  // The single shared 4-bit adder slice: sum nibble nib of P with nibble nib of M.
  always_comb begin
    add_a             = p[WIDTH + 4*int'(nib) +: 4];
    add_b             = m[4*int'(nib) +: 4];
    {add_co, add_sum} = {1'b0, add_a} + {1'b0, add_b} + {4'b0000, c};
  end

  // Right shift of the accumulator with the last adder carry entering at the top.
  assign shifted = {c, p[2*WIDTH-1:1]};

  // Control sequence and datapath registers; reset aborts any operation in flight.
  always_ff @(posedge Clock or negedge Reset_n) begin
    if (!Reset_n) begin
      state   <= IDLE;
      p       <= '0;
      m       <= '0;
      nib     <= '0;
      bitcnt  <= '0;
      c       <= 1'b0;
      product <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (bus.Start) begin
            p      <= {{WIDTH{1'b0}}, bus.Multiplier};
            m      <= bus.Multiplicand;
            nib    <= '0;
            bitcnt <= '0;
            c      <= 1'b0;
            state  <= bus.Multiplier[0] ? ADD : SHIFT;
          end
        end
        ADD: begin
          p[WIDTH + 4*int'(nib) +: 4] <= add_sum;
          c                            <= add_co;
          if (nib == NIB_LAST) begin
            nib   <= '0;
            state <= SHIFT;
          end else begin
            nib <= nib + 1'b1;
          end
        end
        SHIFT: begin
          p <= shifted;
          // Clearing here keeps nibble 0's carry-in at zero for the next add pass.
          c <= 1'b0;
          if (bitcnt == BIT_LAST) begin
            product <= shifted;
            state   <= DONE;
          end else begin
            bitcnt <= bitcnt + 1'b1;
            // p[1] becomes the LSB after this shift, so it picks the next step.
            state  <= p[1] ? ADD : SHIFT;
          end
        end
        DONE: begin
          state <= IDLE;
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

  // Status is decoded purely from the state register, so no input reaches it combinationally.
  assign bus.Busy    = (state != IDLE);
  assign bus.Done    = (state == DONE);
  assign bus.Product = product;

endmodule
